bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Parametrised in binary input width and BCD digit count.
- Uses a start/busy/done handshake and flags results that do not fit in D digits.
- Sits between binary datapath counters and seven-segment/display drivers in the combinational-encoder family.

Parameters:
- W, 8, binary input width in bits; legal W >= 1.
- D, 3, number of BCD output digits; legal D >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only while idle or done.
- bin  input  W  unsigned binary value; captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd, ndig and ovf are valid from this cycle.
- bcd  output  4*D  packed BCD result; digit 0 = bits [3:0] (least significant).
- ndig  output  clog2(D+1)  number of significant digits; 1 for value 0; saturates at D.
- ovf  output  1  high when bin > 10^D-1; bcd then holds bin mod 10^D.

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- Reset: when rst is sampled high, state=IDLE; busy=0, done=0, bcd=0, ndig=0, ovf=0; internal shift and digit registers cleared. rst takes priority over start and over any in-flight conversion. A conversion aborted by reset produces no done.
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1.
  - DONE: busy=0, done=1 for exactly one cycle.
- Transitions:
  - IDLE -> SHIFT on the edge that samples start=1 (edge E0).
  - SHIFT -> DONE after the W-th shift.
  - DONE -> IDLE on the next edge, or DONE -> SHIFT if start=1 is sampled (back-to-back).
- Accept edge E0:
  - load bin into the shift register;
  - clear the digit accumulator and the overflow sticky bit;
  - set the step counter to 0 (counter width clog2(W+1)).
- Each SHIFT edge (E1..EW):
  - for every digit d of the D-digit accumulator, if d >= 5 then d += 3 (all digits adjusted in parallel, before the shift);
  - shift {accumulator, shift register} left by 1;
  - if the bit shifted out of the top digit is 1, set the overflow sticky bit;
  - increment the counter.
- On edge EW:
  - bcd, ovf and ndig update to the final values;
  - done=1 and busy=0 in the following cycle.
- Latency: exactly W edges from accepting start to done visible.
- Throughput: one conversion per W+1 cycles when start is held or re-pulsed on the done cycle.
- start sampled during SHIFT is ignored: no queueing, no restart, the in-flight result is unaffected.
- bin is only sampled at E0; changes to bin during SHIFT have no effect.
- bcd, ndig and ovf hold their last result until the next EW or reset. They are not cleared at start.
- ndig: index of the highest nonzero digit + 1, computed from the final accumulator; 1 when all digits are zero. When ovf=1, ndig = D.
- Invariant: every digit in bcd is <= 9 at all times.
- Overflow correctness: truncated upper digits do not affect the lower digits, so bcd == bin mod 10^D whenever ovf=1.
- W=1 degenerate case: a single SHIFT edge; bcd digit 0 = bin.

Test Plan:
- Defaults W=8, D=3, reset then start with bin=0 -> done exactly 8 edges after accept; bcd=12'h000, ndig=1, ovf=0; busy high for 8 cycles.
- bin=255 -> bcd=12'h255, ndig=3, ovf=0. Sweep bin=0..255 and compare every result to a reference conversion; check each digit <= 9 and done width = 1 cycle.
- start asserted again during SHIFT with a different bin (bin=9, then start with bin=200 at cycle 3) -> second start ignored; result bcd=12'h009, ndig=1. Then start on the done cycle with bin=200 -> accepted immediately; bcd=12'h200 after 8 more edges.
- D=2, W=8: bin=99 -> bcd=8'h99, ovf=0, ndig=2. bin=200 -> bcd=8'h00, ovf=1, ndig=2. bin=255 -> bcd=8'h55, ovf=1.
- Reset mid-conversion: bin=123, assert rst at cycle 4 of SHIFT -> next cycle busy=0, done=0, bcd=0, ndig=0, ovf=0; no done pulse follows. A new start with bin=45 -> bcd=12'h045, ndig=2.
- W=12, D=4: bin=4095 -> bcd=16'h4095, ndig=4, latency 12 edges; bin=1000 -> bcd=16'h1000.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
//
// A conversion is accepted on the edge that samples start=1 while idle or in
// the done cycle. It then runs exactly W shift steps, and done pulses for one
// cycle with bcd/ndig/ovf valid. The results hold until the next conversion
// completes or until reset.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  conversion request; ignored while busy
//   bin    unsigned binary input, captured on the accepting edge
//   busy   high while shift steps are in progress
//   done   one-cycle completion pulse
//   bcd    packed BCD result, digit 0 in bits [3:0]
//   ndig   number of significant digits (1 for zero, D on overflow)
//   ovf    input exceeded 10^D-1; bcd then holds bin mod 10^D
module bin_to_bcd_seq #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [W-1:0]           bin,
  output logic                   busy,
  output logic                   done,
  output logic [4*D-1:0]         bcd,
  output logic [$clog2(D+1)-1:0] ndig,
  output logic                   ovf
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned NW = $clog2(D + 1);
  localparam int unsigned BW = 4 * D;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [BW-1:0] acc_q, acc_d;
  logic          sticky_q, sticky_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic [NW-1:0] ndig_q, ndig_d;
  logic          ovf_q, ovf_d;

  logic [BW-1:0] adj;
  logic [BW+W:0] shifted;
  logic [BW-1:0] acc_step;
  logic [W-1:0]  sh_step;
  logic          carry_out;
  logic          last_step;
  logic [NW-1:0] ndig_calc;

  // Add 3 to every digit >= 5 so the following doubling carries in decimal.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < int'(D); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted   = {adj, sh_q, 1'b0};
  // Carry out of the top digit means the value no longer fits in D digits.
  assign carry_out = shifted[BW+W];
  assign acc_step  = shifted[BW+W-1 -: BW];
  assign sh_step   = shifted[W-1:0];
  assign last_step = (cnt_q == CW'(W - 1));

  // Significant-digit count of the final accumulator.
  always_comb begin
    ndig_calc = NW'(1);
    for (int i = 1; i < int'(D); i++) begin
      if (acc_step[4*i +: 4] != 4'd0) begin
        ndig_calc = NW'(i + 1);
      end
    end
    if (sticky_q || carry_out) begin
      ndig_calc = NW'(D);
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    ndig_d   = ndig_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StShift;
          sh_d     = bin;
          acc_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        sh_d     = sh_step;
        acc_d    = acc_step;
        sticky_d = sticky_q | carry_out;
        cnt_d    = cnt_q + CW'(1);
        if (last_step) begin
          state_d = StDone;
          bcd_d   = acc_step;
          ndig_d  = ndig_calc;
          ovf_d   = sticky_q | carry_out;
        end
      end
      default: state_d = StIdle;
    endcase
    // Status flags are registered from the next state so they align with it.
    busy_d = (state_d == StShift);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sh_q     <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ndig_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bcd_q    <= bcd_d;
      ndig_q   <= ndig_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ndig = ndig_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: four instances (8/3, 8/2, 12/4, 1/1). The 8/3
// instance is tracked cycle by cycle against an arithmetic reference model;
// all instances get directed vectors with hand-computed results.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start_a, busy_a, done_a, ovf_a;
  logic [7:0]  bin_a;
  logic [11:0] bcd_a;
  logic [1:0]  ndig_a;

  logic        start_b, busy_b, done_b, ovf_b;
  logic [7:0]  bin_b;
  logic [7:0]  bcd_b;
  logic [1:0]  ndig_b;

  logic        start_c, busy_c, done_c, ovf_c;
  logic [11:0] bin_c;
  logic [15:0] bcd_c;
  logic [2:0]  ndig_c;

  logic        start_d, busy_d, done_d, ovf_d;
  logic [0:0]  bin_d;
  logic [3:0]  bcd_d;
  logic [0:0]  ndig_d;

  bin_to_bcd_seq #(.W(8), .D(3)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .bin(bin_a), .busy(busy_a),
    .done(done_a), .bcd(bcd_a), .ndig(ndig_a), .ovf(ovf_a)
  );
  bin_to_bcd_seq #(.W(8), .D(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .bin(bin_b), .busy(busy_b),
    .done(done_b), .bcd(bcd_b), .ndig(ndig_b), .ovf(ovf_b)
  );
  bin_to_bcd_seq #(.W(12), .D(4)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .bin(bin_c), .busy(busy_c),
    .done(done_c), .bcd(bcd_c), .ndig(ndig_c), .ovf(ovf_c)
  );
  bin_to_bcd_seq #(.W(1), .D(1)) u_d (
    .clk(clk), .rst(rst), .start(start_d), .bin(bin_d), .busy(busy_d),
    .done(done_d), .bcd(bcd_d), .ndig(ndig_d), .ovf(ovf_d)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference conversion by repeated division.
  function automatic logic [63:0] ref_bcd(input longint unsigned v, input int d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit ref_ovf(input longint unsigned v, input int d);
    longint unsigned lim;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    return v >= lim;
  endfunction

  function automatic int ref_ndig(input longint unsigned v, input int d);
    int n;
    if (ref_ovf(v, d)) return d;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  // Cycle-level model of the 8/3 instance: a countdown of remaining steps.
  logic        m_busy, m_done, m_ovf;
  logic [11:0] m_bcd;
  int          m_ndig;
  int          m_left;
  logic [7:0]  m_val;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_bcd  <= '0;
      m_ndig <= 0;
      m_ovf  <= 1'b0;
      m_left <= 0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_bcd  <= 12'(ref_bcd(m_val, 3));
        m_ndig <= ref_ndig(m_val, 3);
        m_ovf  <= ref_ovf(m_val, 3);
      end
    end else begin
      m_done <= 1'b0;
      if (start_a) begin
        m_val  <= bin_a;
        m_left <= 8;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 64'(busy_a), 64'(m_busy));
      check("cyc_done", 64'(done_a), 64'(m_done));
      check("cyc_bcd", 64'(bcd_a), 64'(m_bcd));
      check("cyc_ndig", 64'(ndig_a), 64'(m_ndig));
      check("cyc_ovf", 64'(ovf_a), 64'(m_ovf));
      check("cyc_digits_le9", 64'((bcd_a[3:0] <= 9) && (bcd_a[7:4] <= 9) && (bcd_a[11:8] <= 9)),
            64'(1));
    end
  end

  // Pulse start on one instance, then count edges after the accept edge until done.
  task automatic run(input int sel, input longint unsigned v, output int lat,
                     output logic [15:0] rb, output logic [63:0] rn, output logic ro);
    bit got;
    got = 1'b0;
    lat = 0;
    case (sel)
      0: begin start_a = 1'b1; bin_a = 8'(v); end
      1: begin start_b = 1'b1; bin_b = 8'(v); end
      2: begin start_c = 1'b1; bin_c = 12'(v); end
      default: begin start_d = 1'b1; bin_d = 1'(v); end
    endcase
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      case (sel)
        0: got = done_a;
        1: got = done_b;
        2: got = done_c;
        default: got = done_d;
      endcase
    end
    if (!got) begin
      n_chk++;
      $display("FAIL done_timeout: instance %0d no done after %0d edges", sel, lat);
    end
    case (sel)
      0: begin rb = 16'(bcd_a); rn = 64'(ndig_a); ro = ovf_a; end
      1: begin rb = 16'(bcd_b); rn = 64'(ndig_b); ro = ovf_b; end
      2: begin rb = bcd_c; rn = 64'(ndig_c); ro = ovf_c; end
      default: begin rb = 16'(bcd_d); rn = 64'(ndig_d); ro = ovf_d; end
    endcase
  endtask

  int          lat, ndone;
  logic [15:0] rb;
  logic [63:0] rn;
  logic        ro;
  bit          got;

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    bin_a = '0; bin_b = '0; bin_c = '0; bin_d = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_busy", 64'(busy_a), 0);
    check("rst_bcd", 64'(bcd_a), 0);
    check("rst_ndig", 64'(ndig_a), 0);
    rst = 1'b0;

    // Zero: 8-edge latency, ndig=1.
    run(0, 0, lat, rb, rn, ro);
    check("zero_lat", 64'(lat), 8);
    check("zero_bcd", 64'(rb), 64'h000);
    check("zero_ndig", rn, 1);
    check("zero_ovf", 64'(ro), 0);

    run(0, 255, lat, rb, rn, ro);
    check("max_bcd", 64'(rb), 64'h255);
    check("max_ndig", rn, 3);
    check("max_ovf", 64'(ro), 0);

    // Full sweep, back-to-back (each start lands on the previous done cycle).
    for (int v = 0; v < 256; v++) begin
      run(0, longint'(v), lat, rb, rn, ro);
      check("sweep_lat", 64'(lat), 8);
      check("sweep_bcd", 64'(rb), ref_bcd(longint'(v), 3));
      check("sweep_ndig", rn, 64'(ref_ndig(longint'(v), 3)));
    end

    // Start during SHIFT is ignored; bin changes during SHIFT have no effect.
    start_a = 1'b1; bin_a = 8'd9;
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      start_a = (lat == 2);
      bin_a   = (lat == 2) ? 8'd200 : 8'd77;
      @(posedge clk); #1;
      lat++;
      got = done_a;
    end
    start_a = 1'b0;
    check("ignore_lat", 64'(lat), 8);
    check("ignore_bcd", 64'(bcd_a), 64'h009);
    check("ignore_ndig", 64'(ndig_a), 1);

    // Start on the done cycle is accepted immediately.
    run(0, 200, lat, rb, rn, ro);
    check("b2b_lat", 64'(lat), 8);
    check("b2b_bcd", 64'(rb), 64'h200);
    check("b2b_ndig", rn, 3);

    // Reset in the fourth SHIFT cycle aborts without a done pulse.
    start_a = 1'b1; bin_a = 8'd123;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 64'(busy_a), 0);
    check("abort_done", 64'(done_a), 0);
    check("abort_bcd", 64'(bcd_a), 0);
    check("abort_ndig", 64'(ndig_a), 0);
    check("abort_ovf", 64'(ovf_a), 0);
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      ndone += int'(done_a);
    end
    check("abort_no_done", 64'(ndone), 0);
    run(0, 45, lat, rb, rn, ro);
    check("after_abort_bcd", 64'(rb), 64'h045);
    check("after_abort_ndig", rn, 2);

    // Two-digit instance: overflow keeps bin mod 100.
    run(1, 99, lat, rb, rn, ro);
    check("d2_99_lat", 64'(lat), 8);
    check("d2_99_bcd", 64'(rb), 64'h99);
    check("d2_99_ovf", 64'(ro), 0);
    check("d2_99_ndig", rn, 2);
    run(1, 200, lat, rb, rn, ro);
    check("d2_200_bcd", 64'(rb), 64'h00);
    check("d2_200_ovf", 64'(ro), 1);
    check("d2_200_ndig", rn, 2);
    run(1, 255, lat, rb, rn, ro);
    check("d2_255_bcd", 64'(rb), 64'h55);
    check("d2_255_ovf", 64'(ro), 1);

    // Twelve-bit, four-digit instance.
    run(2, 4095, lat, rb, rn, ro);
    check("w12_lat", 64'(lat), 12);
    check("w12_4095_bcd", 64'(rb), 64'h4095);
    check("w12_4095_ndig", rn, 4);
    check("w12_4095_ovf", 64'(ro), 0);
    run(2, 1000, lat, rb, rn, ro);
    check("w12_1000_bcd", 64'(rb), 64'h1000);
    check("w12_1000_ndig", rn, 4);

    // Degenerate single-bit instance.
    run(3, 1, lat, rb, rn, ro);
    check("w1_lat", 64'(lat), 1);
    check("w1_one_bcd", 64'(rb), 64'h1);
    check("w1_one_ndig", rn, 1);
    run(3, 0, lat, rb, rn, ro);
    check("w1_zero_bcd", 64'(rb), 64'h0);
    check("w1_zero_ovf", 64'(ro), 0);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
